// File: rtl/data_memory.sv
// Data memory with RV32I byte/half/word load-store alignment and first-fault capture.
// Optional macro DMEM_MISALIGN_TRAP_EN: defined = trap illegal accesses, undefined = force-align.
module data_memory #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [2:0]      funct3,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic [XLEN-1:0] read_data,
  output logic            misaligned,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   widx;
  logic            active;
  logic            legal_f3;
  logic            bad_align;
  logic [1:0]      eff_size;
  logic            blocked;
  logic            we;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic            unused_addr;

  assign widx        = addr[AW+1:2];
  assign unused_addr = ^addr[XLEN-1:AW+2];
  assign active      = !rst && (mem_read || mem_write);

  // Unsigned load codes are illegal for stores; any illegal code falls back to word size.
  always_comb begin
    legal_f3 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = !mem_write;
      default:                legal_f3 = 1'b0;
    endcase
  end

  assign eff_size   = legal_f3 ? funct3[1:0] : SZ_W;
  assign bad_align  = ((eff_size == SZ_H) && addr[0]) ||
                      ((eff_size == SZ_W) && (addr[1:0] != 2'b00));
  assign misaligned = active && (!legal_f3 || bad_align);
  assign blocked    = TRAP && misaligned;
  assign we         = active && mem_write && !blocked;

  // Lane selection ignores the low address bits a wider access does not use,
  // which is exactly the force-align behaviour when misaligned accesses proceed.
  always_comb begin
    be    = 4'b0000;
    wdata = write_data;
    case (eff_size)
      SZ_B: begin
        be[addr[1:0]] = 1'b1;
        wdata         = {4{write_data[7:0]}};
      end
      SZ_H: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rd_word = mem[widx];
  assign rd_byte = rd_word[8*addr[1:0] +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    read_data = '0;
    if (active && !mem_write && !blocked) begin
      case (eff_size)
        SZ_B:    read_data = funct3[2] ? {{(XLEN-8){1'b0}}, rd_byte}
                                       : {{(XLEN-8){rd_byte[7]}}, rd_byte};
        SZ_H:    read_data = funct3[2] ? {{(XLEN-16){1'b0}}, rd_half}
                                       : {{(XLEN-16){rd_half[15]}}, rd_half};
        default: read_data = rd_word;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (misaligned && !fault) begin
      fault      <= 1'b1;
      fault_addr <= addr;
    end
  end
`else
  assign fault      = 1'b0;
  assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed plus randomized bench for data_memory against a byte-array reference model.
module tb_data_memory;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int SPAN  = 4 * DEPTH;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] write_data;
  logic [2:0]      funct3;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] read_data;
  logic            misaligned;
  logic            fault;
  logic [XLEN-1:0] fault_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [SPAN];
  logic        ref_fault;
  logic [31:0] ref_faddr;

  data_memory #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data), .funct3(funct3),
    .mem_read(mem_read), .mem_write(mem_write), .read_data(read_data),
    .misaligned(misaligned), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit code_ok(input logic [2:0] f, input bit st);
    return (f == F_B) || (f == F_H) || (f == F_W) || (!st && (f == F_BU || f == F_HU));
  endfunction

  function automatic int nbytes(input logic [2:0] f, input bit st);
    if (!code_ok(f, st)) return 4;
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit illegal(input logic [31:0] a, input logic [2:0] f, input bit st);
    if (!code_ok(f, st)) return 1'b1;
    return (a % nbytes(f, st)) != 0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [2:0] f,
                                           input bit r, input bit w, input bit rs);
    int n, base;
    logic [31:0] v;
    if (rs || !r || w) return 32'h0;
    if (TRAP && illegal(a, f, 1'b0)) return 32'h0;
    n    = nbytes(f, 1'b0);
    base = int'(a % SPAN);
    base = base - (base % n);
    v    = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (n < 4 && code_ok(f, 1'b0) && !f[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_edge(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                          input bit r, input bit w, input bit rs);
    int n, base;
    bit ill;
    if (rs) begin
      ref_fault = 1'b0;
      ref_faddr = 32'h0;
      return;
    end
    if (!(r || w)) return;
    ill = illegal(a, f, w);
    if (TRAP && ill && !ref_fault) begin
      ref_fault = 1'b1;
      ref_faddr = a;
    end
    if (w && !(TRAP && ill)) begin
      n    = nbytes(f, 1'b1);
      base = int'(a % SPAN);
      base = base - (base % n);
      for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
    end
  endtask

  task automatic step(input string tag, input bit rs, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    rst = rs; mem_read = r; mem_write = w; addr = a; write_data = d; funct3 = f;
    #2;
    check({tag, ".rd"}, read_data, exp_read(a, f, r, w, rs));
    check({tag, ".mis"}, 32'(misaligned), 32'(!rs && (r || w) && illegal(a, f, w)));
    @(posedge clk);
    ref_edge(a, d, f, r, w, rs);
    #1;
    check({tag, ".flt"}, 32'(fault), 32'(ref_fault));
    check({tag, ".fad"}, fault_addr, ref_faddr);
  endtask

  initial begin
    logic [31:0] ra, rd32;
    logic [2:0]  rf;
    bit          rr, rw, rrs;

    ref_fault = 1'b0;
    ref_faddr = 32'h0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; write_data = '0; funct3 = F_W;
    @(posedge clk);
    #1;

    // Reset: outputs quiet even for an illegal load request.
    step("rst0", 1'b1, 1'b1, 1'b0, 32'h31, 32'h0, F_W);
    step("rst1", 1'b1, 1'b0, 1'b1, 32'h45, 32'h0, F_H);

    for (int i = 0; i < 64; i++) step("init", 1'b0, 1'b0, 1'b1, 32'(4 * i), 32'h0, F_W);

    step("sw10", 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, F_W);
    step("lw10", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, F_W);
    check("lw10.const", read_data, 32'hDEADBEEF);

    step("sw10b", 1'b0, 1'b0, 1'b1, 32'h10, 32'h11223344, F_W);
    step("sb13", 1'b0, 1'b0, 1'b1, 32'h13, 32'h80, F_B);
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h13; funct3 = F_B; #2;
    check("lb13.const", read_data, 32'hFFFFFF80);
    funct3 = F_BU; #1;
    check("lbu13.const", read_data, 32'h00000080);
    addr = 32'h10; funct3 = F_W; #1;
    check("lw10c.const", read_data, 32'h80223344);
    @(posedge clk); #1;

    step("sh22", 1'b0, 1'b0, 1'b1, 32'h22, 32'hBEEF, F_H);
    step("lh22", 1'b0, 1'b1, 1'b0, 32'h22, 32'h0, F_H);
    check("lh22.const", read_data, 32'hFFFFBEEF);
    step("lhu22", 1'b0, 1'b1, 1'b0, 32'h22, 32'h0, F_HU);
    check("lhu22.const", read_data, 32'h0000BEEF);
    step("lw20", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, F_W);
    check("lw20.const", read_data, 32'hBEEF0000);

    step("swwrap", 1'b0, 1'b0, 1'b1, 32'h1004, 32'h1234, F_W);
    step("lwwrap", 1'b0, 1'b1, 1'b0, 32'h0004, 32'h0, F_W);
    check("lwwrap.const", read_data, 32'h00001234);

    step("sw8", 1'b0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, F_W);
    step("swlw8", 1'b0, 1'b1, 1'b1, 32'h8, 32'h5A5A0001, F_W);
    step("lw8", 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, F_W);
    check("lw8.const", read_data, 32'h5A5A0001);

    step("lw31", 1'b0, 1'b1, 1'b0, 32'h31, 32'h0, F_W);
    check("lw31.mis", 32'(misaligned), 32'h1);
    step("sh45", 1'b0, 1'b0, 1'b1, 32'h45, 32'hCAFE, F_H);
    step("lw44", 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, F_W);
    step("ill3", 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 3'b011);
    step("sbu", 1'b0, 1'b0, 1'b1, 32'h54, 32'h77665544, F_BU);
    step("lw54", 1'b0, 1'b1, 1'b0, 32'h54, 32'h0, F_W);

    step("sw40", 1'b0, 1'b0, 1'b1, 32'h40, 32'h13579BDF, F_W);
    step("rstsw", 1'b1, 1'b0, 1'b1, 32'h40, 32'h55, F_W);
    step("lw40", 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, F_W);
    check("lw40.const", read_data, 32'h13579BDF);

    for (int k = 0; k < 400; k++) begin
      ra   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      rd32 = $urandom;
      rf   = 3'($urandom_range(0, 7));
      rr   = 1'($urandom);
      rw   = ($urandom_range(0, 2) == 0);
      rrs  = ($urandom_range(0, 40) == 0);
      if (($urandom_range(0, 3) != 0) && code_ok(rf, rw)) begin
        ra = ra - (ra % nbytes(rf, rw));
      end
      step("rnd", rrs, rr, rw, ra, rd32, rf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
